// File: rtl/complement_sequencer.sv
// Operand sequencer for the two-phase two's-complement unit: FIFO in, hold, capture, valid/ready out.
// Optional result cross-check is enabled by defining SEQ_SELF_CHECK_EN (adds the check_error port).
module complement_sequencer #(
  parameter int NUMBER_OF_BITS = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYCLES    = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUMBER_OF_BITS:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUMBER_OF_BITS:0] comp_value,
  input  logic [NUMBER_OF_BITS:0] comp_result,
  output logic [NUMBER_OF_BITS:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef SEQ_SELF_CHECK_EN
  output logic                    check_error,
`endif
  output logic                    busy
);
  localparam int W   = NUMBER_OF_BITS + 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW  = AW + 1;
  localparam int CW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [NW-1:0] DEPTH_C = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, DRIVE, PRESENT} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [NW-1:0]   count;
  logic            full, empty, push, pop;

  // Flow control looks only at registered occupancy, so a same-cycle pop never frees a full FIFO
  // and a push into an empty FIFO is never popped on the same edge.
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SEQ_SELF_CHECK_EN
  logic [W-1:0] op_reg;
  logic [W-1:0] expect_res;
  assign expect_res = ~op_reg + 1'b1;
`endif

  // Operand is held for HOLD_CYCLES+1 edges so the unit's free-running phase toggle
  // completes a latch/compute pair under either alignment before capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      comp_value <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
`ifdef SEQ_SELF_CHECK_EN
      op_reg      <= '0;
      check_error <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            comp_value <= mem[rd_ptr];
`ifdef SEQ_SELF_CHECK_EN
            op_reg     <= mem[rd_ptr];
`endif
            wait_cnt   <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == HOLD_C) begin
            out_data  <= comp_result;
            out_valid <= 1'b1;
            state     <= PRESENT;
`ifdef SEQ_SELF_CHECK_EN
            if (comp_result != expect_res) check_error <= 1'b1;
`endif
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_complement_sequencer.sv
// Bench for complement_sequencer with a behavioural two-phase complement unit and a queue-based reference.
// Define SEQ_SELF_CHECK_EN to also exercise the check_error path.
module tb_complement_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] comp_value;
  logic [3:0] comp_result;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
`ifdef SEQ_SELF_CHECK_EN
  logic       check_error;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Two-phase unit: latches its input in STATE1, publishes the complement in STATE2.
  logic       phase = 1'b0;
  logic [3:0] unit_latch = '0;
  logic [3:0] unit_res = '0;
  logic       force_zero = 1'b0;
  always @(posedge clock) begin
    phase <= ~phase;
    if (!phase) unit_latch <= comp_value;
    else        unit_res   <= ~unit_latch + 4'd1;
  end
  assign comp_result = force_zero ? 4'd0 : unit_res;

  complement_sequencer #(.NUMBER_OF_BITS(3), .FIFO_DEPTH(4), .HOLD_CYCLES(3)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .comp_value(comp_value), .comp_result(comp_result), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SEQ_SELF_CHECK_EN
    .check_error(check_error),
`endif
    .busy(busy)
  );

  function automatic logic [3:0] neg4(input logic [3:0] x);
    return 4'((16 - int'(x)) % 16);
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 4'h5;
    repeat (3) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (comp_value !== 4'h0) begin errors++; $display("FAIL reset_comp_value: got %h expected 0", comp_value); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_push: busy got %b expected 0", busy); end
  endtask

  task automatic test_latency(input logic ph);
    int n = 0;
    out_ready = 1'b1;
    @(negedge clock);
    while (phase !== ph && n < 4) begin @(negedge clock); n++; end
    in_data = 4'b0011; in_valid = 1'b1;
    @(negedge clock);            // push edge passed
    in_valid = 1'b0;
    @(negedge clock);            // pop edge passed
    checks++; if (comp_value !== 4'b0011) begin errors++; $display("FAIL lat%0d_comp_value: got %h expected 3", ph, comp_value); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat%0d_early_valid@%0d: got %b expected 0", ph, k, out_valid); end
    end
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat%0d_valid: got %b expected 1", ph, out_valid); end
    checks++; if (out_data !== 4'b1101) begin errors++; $display("FAIL lat%0d_data: got %h expected d", ph, out_data); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat%0d_handshake: got %b expected 0", ph, out_valid); end
  endtask

  task automatic test_sequence();
    logic [3:0] ops [3];
    int got = 0;
    ops[0] = 4'b0000; ops[1] = 4'b1000; ops[2] = 4'b0111;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); in_data = ops[i]; in_valid = 1'b1;
    end
    @(negedge clock); in_valid = 1'b0;
    for (int c = 0; c < 100 && got < 3; c++) begin
      if (out_valid) begin
        checks++; if (out_data !== neg4(ops[got])) begin errors++; $display("FAIL seq_%0d: got %h expected %h", got, out_data, neg4(ops[got])); end
        got++;
      end
      @(negedge clock);
    end
    checks++; if (got != 3) begin errors++; $display("FAIL seq_count: got %0d expected 3", got); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acc [$];
    int got = 0, extra = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in_data = 4'($urandom_range(0, 15)); in_valid = 1'b1;
      checks++; if (in_ready !== (i < 5)) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b expected %b", i, in_ready, (i < 5)); end
      if (in_ready) acc.push_back(in_data);
    end
    @(negedge clock); in_valid = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stalled_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 200 && acc.size() > 0; c++) begin
      if (out_valid) begin
        checks++; if (out_data !== neg4(acc[0])) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", got, out_data, neg4(acc[0])); end
        void'(acc.pop_front()); got++;
      end
      @(negedge clock);
    end
    for (int c = 0; c < 20; c++) begin
      if (out_valid) extra++;
      @(negedge clock);
    end
    checks++; if (got != 5 || extra != 0) begin errors++; $display("FAIL b2b_count: got %0d+%0d expected 5+0", got, extra); end
  endtask

  task automatic test_hold();
    logic [3:0] op, d;
    int n = 0, seen = 0;
    op = 4'($urandom_range(1, 15));
    out_ready = 1'b0;
    @(negedge clock); in_data = op; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    while (!out_valid && n < 30) begin @(negedge clock); n++; end
    d = out_data;
    checks++; if (out_valid !== 1'b1 || d !== neg4(op)) begin errors++; $display("FAIL hold_first: got %b/%h expected 1/%h", out_valid, d, neg4(op)); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b1 || out_data !== neg4(op)) begin errors++; $display("FAIL hold_stable_%0d: got %b/%h expected 1/%h", c, out_valid, out_data, neg4(op)); end
    end
    out_ready = 1'b1;
    @(negedge clock);
    for (int c = 0; c < 10; c++) begin
      if (out_valid) seen++;
      @(negedge clock);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL hold_single_handshake: got %0d extra expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    int bad_valid = 0, bad_busy = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); in_data = 4'(i + 2); in_valid = 1'b1;
    end
    @(negedge clock); in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    checks++; if (comp_value !== 4'h0) begin errors++; $display("FAIL mid_comp_value: got %h expected 0", comp_value); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (out_valid) bad_valid++;
      if (busy || !in_ready) bad_busy++;
    end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL mid_no_valid: got %0d expected 0", bad_valid); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL mid_idle_empty: got %0d expected 0", bad_busy); end
  endtask

  task automatic test_random();
    logic [3:0] q [$];
    int hs = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      if (in_valid && in_ready) q.push_back(in_data);
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand_spurious: got %h expected none", out_data); end
        else begin
          if (out_data !== neg4(q[0])) begin errors++; $display("FAIL rand_%0d: got %h expected %h", hs, out_data, neg4(q[0])); end
          void'(q.pop_front());
        end
        hs++;
      end
    end
    @(negedge clock); in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 300 && q.size() > 0; c++) begin
      if (out_valid) begin
        checks++; if (out_data !== neg4(q[0])) begin errors++; $display("FAIL rand_drain: got %h expected %h", out_data, neg4(q[0])); end
        void'(q.pop_front());
      end
      @(negedge clock);
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d expected 0", q.size()); end
  endtask

`ifdef SEQ_SELF_CHECK_EN
  task automatic test_self_check();
    int n = 0;
    checks++; if (check_error !== 1'b0) begin errors++; $display("FAIL chk_clear: got %b expected 0", check_error); end
    force_zero = 1'b1; out_ready = 1'b1;
    @(negedge clock); in_data = 4'b0011; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    while (!out_valid && n < 30) begin @(negedge clock); n++; end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL chk_data: got %h expected 0", out_data); end
    checks++; if (check_error !== 1'b1) begin errors++; $display("FAIL chk_set: got %b expected 1", check_error); end
    force_zero = 1'b0;
    repeat (10) @(negedge clock);
    checks++; if (check_error !== 1'b1) begin errors++; $display("FAIL chk_sticky: got %b expected 1", check_error); end
    reset = 1'b1; @(negedge clock); reset = 1'b0; @(negedge clock);
    checks++; if (check_error !== 1'b0) begin errors++; $display("FAIL chk_reset: got %b expected 0", check_error); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency(1'b0);
    test_latency(1'b1);
    test_sequence();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef SEQ_SELF_CHECK_EN
    test_self_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
